// File: rtl/ddr_uart_reader_if.sv
// AXI channel-0 read-side bundle between the readback block (master) and the DDR controller (slave).
interface ddr_uart_reader_if;
  logic [7:0]   DdrCtrl_AID_0;
  logic [31:0]  DdrCtrl_AADDR_0;
  logic [7:0]   DdrCtrl_ALEN_0;
  logic [2:0]   DdrCtrl_ASIZE_0;
  logic [1:0]   DdrCtrl_ABURST_0;
  logic [1:0]   DdrCtrl_ALOCK_0;
  logic         DdrCtrl_AVALID_0;
  logic         DdrCtrl_AREADY_0;
  logic         DdrCtrl_ATYPE_0;
  logic [7:0]   DdrCtrl_RID_0;
  logic [255:0] DdrCtrl_RDATA_0;
  logic         DdrCtrl_RLAST_0;
  logic         DdrCtrl_RVALID_0;
  logic [1:0]   DdrCtrl_RRESP_0;
  logic         DdrCtrl_RREADY_0;

  modport master (
    output DdrCtrl_AID_0, DdrCtrl_AADDR_0, DdrCtrl_ALEN_0, DdrCtrl_ASIZE_0,
           DdrCtrl_ABURST_0, DdrCtrl_ALOCK_0, DdrCtrl_AVALID_0, DdrCtrl_ATYPE_0,
           DdrCtrl_RREADY_0,
    input  DdrCtrl_AREADY_0, DdrCtrl_RID_0, DdrCtrl_RDATA_0, DdrCtrl_RLAST_0,
           DdrCtrl_RVALID_0, DdrCtrl_RRESP_0
  );

  modport slave (
    input  DdrCtrl_AID_0, DdrCtrl_AADDR_0, DdrCtrl_ALEN_0, DdrCtrl_ASIZE_0,
           DdrCtrl_ABURST_0, DdrCtrl_ALOCK_0, DdrCtrl_AVALID_0, DdrCtrl_ATYPE_0,
           DdrCtrl_RREADY_0,
    output DdrCtrl_AREADY_0, DdrCtrl_RID_0, DdrCtrl_RDATA_0, DdrCtrl_RLAST_0,
           DdrCtrl_RVALID_0, DdrCtrl_RRESP_0
  );
endinterface

// File: rtl/ddr_uart_reader.sv
// Reads 256-bit DDR beats one at a time over AXI and streams each beat's 32 bytes out of an 8N1 UART.
module ddr_uart_reader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic               axi_clk,
  input  logic               rst,
  input  logic               i_trig,
  input  logic [15:0]        i_num_beats,
  ddr_uart_reader_if.master  axi,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, RDATA, TX, NEXT} state_t;

  state_t           state;
  logic [31:0]      addr;
  logic [15:0]      count;
  logic [255:0]     beat_buf;
  logic [7:0]       shift;
  logic [4:0]       byte_idx;
  logic [3:0]       bit_idx;
  logic [CNT_W-1:0] clk_cnt;
  logic             avalid;
  logic             rready;

  assign axi.DdrCtrl_AID_0    = 8'd0;
  assign axi.DdrCtrl_ALEN_0   = 8'd0;
  assign axi.DdrCtrl_ASIZE_0  = 3'b101;
  assign axi.DdrCtrl_ABURST_0 = 2'b01;
  assign axi.DdrCtrl_ALOCK_0  = 2'b00;
  assign axi.DdrCtrl_ATYPE_0  = 1'b0;
  assign axi.DdrCtrl_AADDR_0  = addr;
  assign axi.DdrCtrl_AVALID_0 = avalid;
  assign axi.DdrCtrl_RREADY_0 = rready;

  // Beat id and last flag carry no information for single-beat reads.
  logic unused_rfields;
  assign unused_rfields = ^{axi.DdrCtrl_RID_0, axi.DdrCtrl_RLAST_0};

  always_ff @(posedge axi_clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= BASE_ADDR;
      count    <= 16'd0;
      beat_buf <= '0;
      shift    <= 8'd0;
      byte_idx <= 5'd0;
      bit_idx  <= 4'd0;
      clk_cnt  <= '0;
      avalid   <= 1'b0;
      rready   <= 1'b0;
      o_tx     <= 1'b1;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_trig) begin
            if (i_num_beats != 16'd0) begin
              addr   <= BASE_ADDR;
              count  <= i_num_beats;
              o_err  <= 1'b0;
              o_busy <= 1'b1;
              avalid <= 1'b1;
              state  <= ADDR;
            end else begin
              o_done <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (axi.DdrCtrl_AREADY_0) begin
            avalid <= 1'b0;
            rready <= 1'b1;
            state  <= RDATA;
          end
        end
        RDATA: begin
          // Capture cycle also launches the start bit of byte 0.
          if (axi.DdrCtrl_RVALID_0) begin
            beat_buf <= axi.DdrCtrl_RDATA_0;
            shift    <= axi.DdrCtrl_RDATA_0[7:0];
            if (axi.DdrCtrl_RRESP_0 != 2'b00) o_err <= 1'b1;
            rready   <= 1'b0;
            o_tx     <= 1'b0;
            byte_idx <= 5'd0;
            bit_idx  <= 4'd0;
            clk_cnt  <= '0;
            state    <= TX;
          end
        end
        TX: begin
          if (clk_cnt != BIT_LAST) begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end else begin
            clk_cnt <= '0;
            if (bit_idx == 4'd9) begin
              if (byte_idx == 5'd31) begin
                state <= NEXT;
              end else begin
                byte_idx <= byte_idx + 5'd1;
                bit_idx  <= 4'd0;
                o_tx     <= 1'b0;
                shift    <= beat_buf[{byte_idx + 5'd1, 3'b000} +: 8];
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              if (bit_idx == 4'd8) begin
                o_tx <= 1'b1;
              end else begin
                o_tx  <= shift[0];
                shift <= {1'b0, shift[7:1]};
              end
            end
          end
        end
        NEXT: begin
          if (count == 16'd1) begin
            count  <= 16'd0;
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            count  <= count - 16'd1;
            addr   <= addr + 32'd32;
            avalid <= 1'b1;
            state  <= ADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_uart_reader.sv
// Directed bench for ddr_uart_reader: AXI read responder, UART frame decoder and handshake observers.
module tb_ddr_uart_reader;
  localparam int unsigned CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig;
  logic [15:0] nb;
  logic        tx, busy, done, err;

  ddr_uart_reader_if bus ();

  ddr_uart_reader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h0000_0000)) dut (
    .axi_clk(clk), .rst(rst), .i_trig(trig), .i_num_beats(nb), .axi(bus),
    .o_tx(tx), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int          ready_delay = 3;
  int          err_beat    = -1;
  int          beat_no     = 0;
  logic [31:0] hs_addr[$];
  logic [7:0]  rx[$];
  int          done_cnt, avalid_seen, tx_low_seen, addr_changed, frame_err;
  int          cyc = 0;
  int          first_low_cyc = -1;
  int          done_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mkdata(input int b);
    logic [255:0] d;
    for (int n = 0; n < 32; n++) d[n*8 +: 8] = 8'(b * 32 + n);
    return d;
  endfunction

  task automatic clr();
    hs_addr.delete();
    rx.delete();
    done_cnt = 0; avalid_seen = 0; tx_low_seen = 0; addr_changed = 0;
    frame_err = 0; first_low_cyc = -1; beat_no = 0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (!done && n < maxc) begin @(negedge clk); n++; end
    chk("done_wait", 32'(done), 32'd1);
  endtask

  task automatic wait_beats(input int k, input int maxc);
    int n = 0;
    while (beat_no < k && n < maxc) begin @(negedge clk); n++; end
    chk("beat_wait", 32'(beat_no >= k), 32'd1);
  endtask

  task automatic wait_txlow(input int maxc);
    int n = 0;
    while (tx && n < maxc) begin @(negedge clk); n++; end
    chk("txlow_wait", 32'(tx), 32'd0);
  endtask

  task automatic pulse_trig(input logic [15:0] beats);
    trig = 1'b1; nb = beats;
    @(negedge clk);
    trig = 1'b0;
  endtask

  // AXI slave: AREADY after ready_delay cycles of AVALID, RVALID two cycles after each address.
  initial begin
    int wcnt = 0;
    int rwait = -1;
    bit rv_acc = 1'b0;
    bus.DdrCtrl_AREADY_0 = 1'b0;
    bus.DdrCtrl_RVALID_0 = 1'b0;
    bus.DdrCtrl_RDATA_0  = '0;
    bus.DdrCtrl_RRESP_0  = 2'b00;
    bus.DdrCtrl_RID_0    = 8'd0;
    bus.DdrCtrl_RLAST_0  = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.DdrCtrl_AREADY_0 = 1'b0;
        bus.DdrCtrl_RVALID_0 = 1'b0;
        wcnt = 0; rwait = -1; rv_acc = 1'b0;
      end else begin
        if (bus.DdrCtrl_AREADY_0) begin
          hs_addr.push_back(bus.DdrCtrl_AADDR_0);
          bus.DdrCtrl_AREADY_0 = 1'b0;
          wcnt = 0; rwait = 2;
        end else if (bus.DdrCtrl_AVALID_0) begin
          if (wcnt >= ready_delay) bus.DdrCtrl_AREADY_0 = 1'b1;
          else wcnt++;
        end
        if (rv_acc) begin
          bus.DdrCtrl_RVALID_0 = 1'b0;
          rv_acc = 1'b0;
          beat_no++;
        end else if (bus.DdrCtrl_RVALID_0 && bus.DdrCtrl_RREADY_0) begin
          rv_acc = 1'b1;
        end
        if (rwait > 0) rwait--;
        else if (rwait == 0) begin
          bus.DdrCtrl_RDATA_0  = mkdata(beat_no);
          bus.DdrCtrl_RRESP_0  = (beat_no == err_beat) ? 2'b10 : 2'b00;
          bus.DdrCtrl_RVALID_0 = 1'b1;
          rwait = -1;
        end
      end
    end
  end

  // Per-cycle observers: done pulses, AVALID activity, address stability, first start bit.
  initial begin
    logic        prev_av = 1'b0;
    logic        prev_ar = 1'b0;
    logic [31:0] prev_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (bus.DdrCtrl_AVALID_0) avalid_seen++;
      if (!tx) begin
        tx_low_seen++;
        if (first_low_cyc < 0) first_low_cyc = cyc;
      end
      if (!rst && prev_av && !prev_ar &&
          (!bus.DdrCtrl_AVALID_0 || bus.DdrCtrl_AADDR_0 != prev_addr)) addr_changed++;
      prev_av   = bus.DdrCtrl_AVALID_0 && !rst;
      prev_ar   = bus.DdrCtrl_AREADY_0;
      prev_addr = bus.DdrCtrl_AADDR_0;
    end
  end

  // UART decoder: one sample per bit period, abandons the frame if reset is seen.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !tx) begin
        logic [7:0] b;
        bit ok;
        b = 8'd0; ok = 1'b1;
        for (int i = 0; i < 9; i++) begin
          for (int k = 0; k < int'(CPB); k++) begin
            @(negedge clk);
            if (rst) ok = 1'b0;
          end
          if (!ok) break;
          if (i < 8) b[i] = tx;
          else if (!tx) frame_err++;
        end
        if (ok) rx.push_back(b);
      end
    end
  end

  initial begin
    rst = 1'b1; trig = 1'b0; nb = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_avalid", 32'(bus.DdrCtrl_AVALID_0), 32'd0);
    chk("rst_rready", 32'(bus.DdrCtrl_RREADY_0), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_aaddr", bus.DdrCtrl_AADDR_0, 32'h0);
    chk("aid", 32'(bus.DdrCtrl_AID_0), 32'd0);
    chk("alen", 32'(bus.DdrCtrl_ALEN_0), 32'd0);
    chk("asize", 32'(bus.DdrCtrl_ASIZE_0), 32'd5);
    chk("aburst", 32'(bus.DdrCtrl_ABURST_0), 32'd1);
    chk("alock", 32'(bus.DdrCtrl_ALOCK_0), 32'd0);
    chk("atype", 32'(bus.DdrCtrl_ATYPE_0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single beat, byte n = n.
    clr(); ready_delay = 3; err_beat = -1;
    pulse_trig(16'd1);
    chk("a_busy", 32'(busy), 32'd1);
    chk("a_avalid", 32'(bus.DdrCtrl_AVALID_0), 32'd1);
    wait_done(3000);
    @(negedge clk);
    chk("a_done_lat", 32'(done_cyc - first_low_cyc), 32'(320 * CPB + 1));
    chk("a_hs_cnt", 32'(hs_addr.size()), 32'd1);
    chk("a_hs_addr", hs_addr[0], 32'h0);
    chk("a_nbytes", 32'(rx.size()), 32'd32);
    for (int i = 0; i < 32; i++) chk("a_byte", 32'(rx[i]), 32'(i));
    chk("a_frame", 32'(frame_err), 32'd0);
    chk("a_done_cnt", 32'(done_cnt), 32'd1);
    chk("a_err", 32'(err), 32'd0);
    chk("a_busy_end", 32'(busy), 32'd0);

    // Three beats, error response on the second.
    clr(); err_beat = 1;
    pulse_trig(16'd3);
    wait_beats(1, 3000);
    chk("b_err_beat1", 32'(err), 32'd0);
    wait_beats(2, 3000);
    chk("b_err_beat2", 32'(err), 32'd1);
    wait_done(3000);
    @(negedge clk);
    chk("b_hs_cnt", 32'(hs_addr.size()), 32'd3);
    chk("b_addr0", hs_addr[0], 32'h00);
    chk("b_addr1", hs_addr[1], 32'h20);
    chk("b_addr2", hs_addr[2], 32'h40);
    chk("b_nbytes", 32'(rx.size()), 32'd96);
    for (int i = 0; i < 96; i++) chk("b_byte", 32'(rx[i]), 32'(i));
    chk("b_done_cnt", 32'(done_cnt), 32'd1);
    chk("b_err_hold", 32'(err), 32'd1);
    err_beat = -1;

    // Zero-beat request.
    clr();
    trig = 1'b1; nb = 16'd0;
    @(negedge clk);
    trig = 1'b0;
    chk("c_done", 32'(done), 32'd1);
    chk("c_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("c_done_off", 32'(done), 32'd0);
    repeat (20) @(negedge clk);
    chk("c_avalid", 32'(avalid_seen), 32'd0);
    chk("c_tx", 32'(tx_low_seen), 32'd0);
    chk("c_done_cnt", 32'(done_cnt), 32'd1);

    // Slow AREADY plus retriggers while busy.
    clr(); ready_delay = 50;
    pulse_trig(16'd1);
    chk("d_err_clr", 32'(err), 32'd0);
    repeat (20) @(negedge clk);
    pulse_trig(16'd5);
    chk("d_avalid_wait", 32'(bus.DdrCtrl_AVALID_0), 32'd1);
    wait_txlow(200);
    pulse_trig(16'd5);
    wait_done(3000);
    @(negedge clk);
    repeat (20) @(negedge clk);
    chk("d_hs_cnt", 32'(hs_addr.size()), 32'd1);
    chk("d_hs_addr", hs_addr[0], 32'h0);
    chk("d_addr_stable", 32'(addr_changed), 32'd0);
    chk("d_nbytes", 32'(rx.size()), 32'd32);
    chk("d_done_cnt", 32'(done_cnt), 32'd1);
    chk("d_busy", 32'(busy), 32'd0);

    // Reset inside data bit 4 of byte 10, then restart.
    clr(); ready_delay = 3;
    pulse_trig(16'd2);
    wait_txlow(100);
    repeat (421) @(negedge clk);
    chk("e_bit4", 32'(tx), 32'd0);
    chk("e_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("e_tx", 32'(tx), 32'd1);
    chk("e_busy", 32'(busy), 32'd0);
    chk("e_avalid", 32'(bus.DdrCtrl_AVALID_0), 32'd0);
    chk("e_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("e_no_done", 32'(done_cnt), 32'd0);
    chk("e_rx_partial", 32'(rx.size()), 32'd10);
    clr();
    pulse_trig(16'd1);
    wait_done(3000);
    @(negedge clk);
    chk("e_hs_cnt", 32'(hs_addr.size()), 32'd1);
    chk("e_restart_addr", hs_addr[0], 32'h0);
    chk("e_nbytes", 32'(rx.size()), 32'd32);
    for (int i = 0; i < 32; i++) chk("e_byte", 32'(rx[i]), 32'(i));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ddr_uart_reader.md
DDR_UART_READER -- requirements
Module: ddr_uart_reader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, is the number of axi_clk cycles per UART bit (115200 baud at 100 MHz).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, is the DDR byte address of the first beat read.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 axi_clk  in  1  sole clock; AXI channel 0 clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 i_trig  in  1  start-readback pulse, sampled at an axi_clk rising edge.
REQ-007 i_num_beats  in  16  number of 256-bit beats to read, sampled when a start is accepted.
REQ-008 DdrCtrl_AID_0 / AADDR_0 / ALEN_0 / ASIZE_0 / ABURST_0 / ALOCK_0  out  8/32/8/3/2/2  AXI address channel fields.
REQ-009 DdrCtrl_AVALID_0  out  1  address valid; DdrCtrl_AREADY_0  in  1  address ready; DdrCtrl_ATYPE_0  out  1  operation type, 0 = read.
REQ-010 DdrCtrl_RID_0 / RDATA_0 / RLAST_0 / RVALID_0 / RRESP_0  in  8/256/1/1/2  AXI read data channel; DdrCtrl_RREADY_0  out  1  read ready.
REQ-011 o_tx  out  1  UART serial output, idle high.
REQ-012 o_busy  out  1  readback in progress; o_done  out  1  one-cycle completion pulse; o_err  out  1  sticky read-error flag.

Function
REQ-013 Constant outputs SHALL be: AID=0, ALEN=0 (single beat), ASIZE=3'b101 (32 B), ABURST=2'b01, ALOCK=0, ATYPE=0.
REQ-014 State machine states SHALL be IDLE, ADDR, RDATA, TX, NEXT.
REQ-015 IDLE: i_trig=1 with i_num_beats>0 SHALL load the address to BASE_ADDR and the count to i_num_beats, clear o_err, set o_busy, and go to ADDR on the next cycle.
REQ-016 IDLE: i_trig=1 with i_num_beats=0 SHALL pulse o_done the following cycle, with no AXI activity and o_busy remaining low.
REQ-017 i_trig SHALL be ignored while o_busy=1.
REQ-018 ADDR: AVALID SHALL be high with AADDR stable until AVALID&&AREADY, then go to RDATA; AVALID SHALL drop in the cycle after the handshake.
REQ-019 RDATA: RREADY SHALL be high; on RVALID&&RREADY, RDATA is captured into a 256-bit buffer and the state goes to TX.
REQ-020 RDATA: RRESP≠2'b00 on the captured beat SHALL set o_err; the beat is still transmitted.
REQ-021 RID and RLAST SHALL be ignored.
REQ-022 TX: the 32 buffer bytes SHALL be sent byte 0 (RDATA[7:0]) first through byte 31 (RDATA[255:248]) last.
REQ-023 Each byte SHALL be framed 8N1: start bit 0, data bits LSB first, stop bit 1, each bit lasting exactly CLKS_PER_BIT cycles, with no idle gap between bytes.
REQ-024 A beat SHALL take exactly 320*CLKS_PER_BIT cycles in TX.
REQ-025 NEXT: the count SHALL decrement. If the result is >0, the address increments by 32 (mod 2^32, wraps from FFFF_FFE0 to 0000_0000) and the state returns to ADDR. If the result is 0, o_done pulses for one cycle, o_busy clears, and the state returns to IDLE.
REQ-026 Only one AXI read SHALL be outstanding at any time; no new address is issued until the buffered beat has been fully transmitted.
REQ-027 RVALID arriving outside RDATA SHALL be ignored (RREADY=0).

Reset
REQ-028 On rst=1 at a clock edge the outputs SHALL be: o_tx=1, AVALID=0, RREADY=0, o_busy=0, o_done=0, o_err=0, AADDR=BASE_ADDR, and the state SHALL be IDLE.
REQ-029 Reset asserted mid-operation SHALL abandon the transfer immediately, including any partial UART frame (o_tx forced high), with no completion pulse.

Verification
REQ-030 rst, then i_trig with i_num_beats=1, responder AREADY after 3 cycles, RDATA=256'h...1F1E..0100 (byte n = n), RRESP=0 -> one address handshake at 0x0; o_tx emits bytes 0x00..0x1F in 8N1; o_done pulses 320*CLKS_PER_BIT+few cycles after RDATA; o_err=0.
REQ-031 i_num_beats=3 -> AADDR sequence 0x00, 0x20, 0x40; exactly 96 UART bytes; a single o_done pulse.
REQ-032 i_trig with i_num_beats=0 -> o_done high one cycle later; AVALID never asserts; o_tx stays 1.
REQ-033 RRESP=2'b10 on beat 2 of 3 -> o_err=1 from capture to next start; all 96 bytes still sent.
REQ-034 Responder holds AREADY=0 for 50 cycles, and i_trig is pulsed again mid-transfer -> AVALID and AADDR stay stable throughout, and the second trigger is ignored.
REQ-035 Reset during the bit-4 of byte 10 -> next cycle o_tx=1, o_busy=0, AVALID=0; a fresh trigger restarts at BASE_ADDR.
